// File: rtl/apb_req_scheduler_if.sv
// Requester-side handshake and APB bus bundle for apb_req_scheduler.
// "master" is the scheduler's view; "slave" is the requesters plus APB slaves.
interface apb_req_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]                  req;
  logic [NUM_REQ-1:0]                  req_write;
  logic [NUM_REQ*(ADDR_WIDTH+1)-1:0]   req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata;
  logic [NUM_REQ-1:0]                  gnt;
  logic [NUM_REQ-1:0]                  done;
  logic [DATA_WIDTH-1:0]               rdata;
  logic                                err;

  logic                                PSEL1;
  logic                                PSEL2;
  logic                                PENABLE;
  logic                                PWRITE;
  logic [ADDR_WIDTH-1:0]               PADDR;
  logic [DATA_WIDTH-1:0]               PWDATA;
  logic [DATA_WIDTH-1:0]               PRDATA;
  logic                                PREADY;
  logic                                PSLVERR;

  modport master (
    input  req, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    output gnt, done, rdata, err, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    input  gnt, done, rdata, err, PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_req_scheduler.sv
// Round-robin scheduler sharing one APB master port among NUM_REQ requesters,
// with two-slave decode on the address MSB and a PREADY timeout.
module apb_req_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  apb_req_scheduler_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW1   = ADDR_WIDTH + 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       owner;
  logic [TO_W-1:0]        cnt;

  logic [NUM_REQ-1:0]     gnt_q;
  logic [NUM_REQ-1:0]     done_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   err_q;
  logic                   psel1_q;
  logic                   psel2_q;
  logic                   penable_q;
  logic                   pwrite_q;
  logic [ADDR_WIDTH-1:0]  paddr_q;
  logic [DATA_WIDTH-1:0]  pwdata_q;

  // Round-robin search starting at rr_ptr
  logic                   win_vld;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       cand;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_vld && bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  logic                   w_write;
  logic [AW1-1:0]         w_addr;
  logic [DATA_WIDTH-1:0]  w_wdata;

  always_comb begin
    w_write = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IDX_W'(k)) begin
        w_write = bus.req_write[k];
        w_addr  = bus.req_addr[k*AW1 +: AW1];
        w_wdata = bus.req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  logic finish;
  logic launch;

  always_comb begin
    finish = (state == ACCESS) && (bus.PREADY || (cnt == TO_W'(TIMEOUT - 1)));
    launch = win_vld && ((state == IDLE) || finish);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      cnt       <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;

      case (state)
        IDLE: ;
        SETUP: begin
          state     <= ACCESS;
          penable_q <= 1'b1;
          cnt       <= '0;
        end
        ACCESS: begin
          if (finish) begin
            done_q <= NUM_REQ'(1) << owner;
            if (bus.PREADY) begin
              err_q <= bus.PSLVERR;
              if (!pwrite_q) rdata_q <= bus.PRDATA;
            end else begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
            cnt       <= '0;
            state     <= IDLE;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // A new grant overrides the return-to-IDLE values set above.
      if (launch) begin
        state     <= SETUP;
        gnt_q     <= NUM_REQ'(1) << win_idx;
        owner     <= win_idx;
        rr_ptr    <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        psel1_q   <= ~w_addr[ADDR_WIDTH];
        psel2_q   <= w_addr[ADDR_WIDTH];
        penable_q <= 1'b0;
        pwrite_q  <= w_write;
        paddr_q   <= w_addr[ADDR_WIDTH-1:0];
        pwdata_q  <= w_wdata;
      end
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.rdata   = rdata_q;
  assign bus.err     = err_q;
  assign bus.PSEL1   = psel1_q;
  assign bus.PSEL2   = psel2_q;
  assign bus.PENABLE = penable_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_req_scheduler.sv
// Directed bench for apb_req_scheduler: single write, wait-state read,
// round-robin contention, slave error, timeout and mid-transfer reset.
module tb_apb_req_scheduler;

  localparam int NUM_REQ = 4;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int TMO     = 16;

  logic pclk;
  logic presetn;
  int   tests = 0;
  int   fails = 0;

  apb_req_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_req_scheduler #(
    .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)
  ) dut (
    .PCLK   (pclk),
    .PRESETn(presetn),
    .bus    (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic wr, input logic [AW:0] addr,
                         input logic [DW-1:0] wdata);
    bus.req_write[idx]            = wr;
    bus.req_addr[idx*(AW+1) +: AW+1] = addr;
    bus.req_wdata[idx*DW +: DW]   = wdata;
  endtask

  task automatic check_bus(input string tag, input logic [3:0] g, input logic [3:0] d,
                           input logic s1, input logic s2, input logic en);
    check({tag, ".gnt"},     32'(bus.gnt),     32'(g));
    check({tag, ".done"},    32'(bus.done),    32'(d));
    check({tag, ".PSEL1"},   32'(bus.PSEL1),   32'(s1));
    check({tag, ".PSEL2"},   32'(bus.PSEL2),   32'(s2));
    check({tag, ".PENABLE"}, 32'(bus.PENABLE), 32'(en));
  endtask

  initial begin
    presetn       = 1'b0;
    bus.req       = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b0;

    // Reset state
    tick();
    tick();
    check_bus("rst", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("rst.rdata", 32'(bus.rdata), 32'h0);
    check("rst.err",   32'(bus.err),   32'h0);
    presetn = 1'b1;
    tick();
    check_bus("idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Single zero-wait write, requester 0 -> slave 0; PRDATA junk must be ignored
    set_req(0, 1'b1, 9'h005, 8'hA5);
    bus.PRDATA = 8'hEE;
    bus.req    = 4'b0001;
    tick();
    check_bus("wr.setup", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
    check("wr.PADDR",  32'(bus.PADDR),  32'h05);
    check("wr.PWRITE", 32'(bus.PWRITE), 32'h1);
    check("wr.PWDATA", 32'(bus.PWDATA), 32'hA5);
    bus.req = 4'b0000;
    tick();
    check_bus("wr.access", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
    tick();
    check_bus("wr.done", 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
    check("wr.err",   32'(bus.err),   32'h0);
    check("wr.rdata", 32'(bus.rdata), 32'h0);
    tick();
    check("wr.done_pulse", 32'(bus.done), 32'h0);

    // Read from slave 1 with two wait states, requester 2
    set_req(2, 1'b0, 9'h10C, 8'h00);
    bus.PREADY = 1'b0;
    bus.req    = 4'b0100;
    tick();
    check_bus("rd.setup", 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("rd.PADDR",  32'(bus.PADDR),  32'h0C);
    check("rd.PWRITE", 32'(bus.PWRITE), 32'h0);
    bus.req = 4'b0000;
    tick();
    check_bus("rd.acc1", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
    tick();
    check_bus("rd.acc2", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
    tick();
    check_bus("rd.acc3", 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
    bus.PREADY = 1'b1;
    bus.PRDATA = 8'h3C;
    tick();
    check_bus("rd.done", 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);
    check("rd.rdata", 32'(bus.rdata), 32'h3C);
    check("rd.err",   32'(bus.err),   32'h0);

    // Reset so the round-robin pointer restarts at requester 0
    presetn = 1'b0;
    tick();
    check("rst2.rdata", 32'(bus.rdata), 32'h0);
    presetn = 1'b1;

    // Contention: all four held, zero-wait, requester 1 lives on slave 1
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, (i == 1) ? 9'h122 : 9'(i), 8'(8'h10 + i));
    bus.PRDATA = 8'hEE;
    bus.req    = 4'b1111;
    tick();
    check_bus("rr.g0", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("rr.access_en", 32'(bus.PENABLE), 32'h1);
      tick();
      check_bus("rr.handover", 4'(1 << (k % 4)), 4'(1 << ((k - 1) % 4)),
                (k % 4) != 1, (k % 4) == 1, 1'b0);
      check("rr.PADDR",  32'(bus.PADDR),  (k % 4 == 1) ? 32'h22 : 32'(k % 4));
      check("rr.PWDATA", 32'(bus.PWDATA), 32'(8'h10 + (k % 4)));
    end
    bus.req = 4'b0000;
    tick();
    tick();
    check_bus("rr.end", 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
    tick();
    check_bus("rr.idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Slave error on a write (pointer now at 1), then a clean read clears err
    set_req(1, 1'b1, 9'h122, 8'h77);
    bus.PSLVERR = 1'b1;
    bus.req     = 4'b0010;
    tick();
    check("se.gnt", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    tick();
    tick();
    check("se.done",  32'(bus.done),  32'h2);
    check("se.err",   32'(bus.err),   32'h1);
    check("se.rdata", 32'(bus.rdata), 32'h0);
    bus.PSLVERR = 1'b0;
    set_req(3, 1'b0, 9'h003, 8'h00);
    bus.PRDATA = 8'h5A;
    bus.req    = 4'b1000;
    tick();
    check("cl.gnt", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0000;
    tick();
    tick();
    check("cl.done",  32'(bus.done),  32'h8);
    check("cl.err",   32'(bus.err),   32'h0);
    check("cl.rdata", 32'(bus.rdata), 32'h5A);

    // Timeout: PREADY stuck low for exactly TIMEOUT ACCESS cycles
    set_req(0, 1'b0, 9'h000, 8'h00);
    bus.PREADY = 1'b0;
    bus.req    = 4'b0001;
    tick();
    check("to.gnt", 32'(bus.gnt), 32'h1);
    bus.req = 4'b0000;
    tick();
    check_bus("to.acc1", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
    for (int c = 2; c <= TMO; c++) begin
      tick();
      check_bus("to.accn", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
    end
    tick();
    check_bus("to.done", 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0);
    check("to.err",   32'(bus.err),   32'h1);
    check("to.rdata", 32'(bus.rdata), 32'h0);
    tick();
    check_bus("to.idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Reset in the second ACCESS cycle, then requester 0 wins over 3
    set_req(2, 1'b1, 9'h044, 8'h99);
    bus.req = 4'b0100;
    tick();
    check("mr.gnt", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0000;
    tick();
    tick();
    check_bus("mr.acc2", 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
    #2;
    presetn = 1'b0;
    #1;
    check_bus("mr.async", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("mr.err", 32'(bus.err), 32'h0);
    set_req(0, 1'b1, 9'h001, 8'h01);
    set_req(3, 1'b1, 9'h103, 8'h03);
    bus.PREADY = 1'b1;
    bus.req    = 4'b1001;
    tick();
    check_bus("mr.held", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    presetn = 1'b1;
    tick();
    check_bus("mr.g0", 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    check_bus("mr.g3", 4'b1000, 4'b0001, 1'b0, 1'b1, 1'b0);
    bus.req = 4'b0000;
    tick();
    tick();
    check_bus("mr.done3", 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
